// File: rtl/iro_meter.sv
// Ring-oscillator frequency meter: counts synchronized rising edges of one phase tap over a 2^(n+4) cycle window.
// Optional IRO_METER_SNAPSHOT_EN synchronizes all 16 taps and captures them into `snapshot` at window end.
module iro_meter (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] phases,
   input  logic [3:0]  sel,
   input  logic [3:0]  gate_log2,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [11:0] count,
   output logic        overflow,
   output logic [15:0] snapshot
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  sel_q, sel_d;
   logic [3:0]  exp_q, exp_d;
   logic [14:0] timer_q, timer_d;
   logic [11:0] cnt_q, cnt_d;
   logic        ovf_q, ovf_d;
   logic [11:0] count_q, count_d;
   logic [15:0] snap_q, snap_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        prev_q, prev_d;
   logic        sync_s;
   logic        edge_s;
   logic [14:0] win_last_s;
   logic [15:0] snap_src_s;

`ifdef IRO_METER_SNAPSHOT_EN
   logic [15:0] meta_q, meta_d;
   logic [15:0] sync_q, sync_d;

   // Two-flop synchronizer across every phase tap
   always_comb begin
      meta_d = phases;
      sync_d = meta_q;
   end

   // Synchronizer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 16'h0000;
         sync_q <= 16'h0000;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign sync_s     = sync_q[sel_q];
   assign snap_src_s = sync_q;
`else
   logic meta_q, meta_d;
   logic sync_q, sync_d;

   // Two-flop synchronizer on the selected tap only
   always_comb begin
      meta_d = phases[sel_q];
      sync_d = meta_q;
   end

   // Synchronizer registers
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign sync_s     = sync_q;
   assign snap_src_s = 16'h0000;
`endif

   assign edge_s     = sync_s & ~prev_q;
   assign win_last_s = 15'h7FFF >> (4'd11 - exp_q);

   // Next-state, counter and output logic
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      exp_d   = exp_q;
      timer_d = timer_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      count_d = count_q;
      snap_d  = snap_q;
      prev_d  = sync_s;
      case (state_q)
         IDLE: begin
            if (start) begin
               sel_d   = sel;
               exp_d   = (gate_log2 > 4'd11) ? 4'd11 : gate_log2;
               cnt_d   = 12'd0;
               ovf_d   = 1'b0;
               timer_d = 15'd0;
               state_d = ARM;
            end else begin
               state_d = IDLE;
            end
         end
         ARM: begin
            // Three cycles let the synchronizer and previous-sample flop settle on the new tap
            if (timer_q == 15'd2) begin
               timer_d = 15'd0;
               state_d = COUNT;
            end else begin
               timer_d = timer_q + 15'd1;
            end
         end
         COUNT: begin
            if (edge_s) begin
               if (cnt_q == 12'hFFF) begin
                  ovf_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 12'd1;
               end
            end else begin
               cnt_d = cnt_q;
            end
            if (timer_q == win_last_s) begin
               timer_d = 15'd0;
               count_d = cnt_d;
               snap_d  = snap_src_s;
               state_d = DONE;
            end else begin
               timer_d = timer_q + 15'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == ARM) || (state_d == COUNT);
      done_d = (state_d == DONE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= 4'd0;
         exp_q   <= 4'd0;
         timer_q <= 15'd0;
         cnt_q   <= 12'd0;
         ovf_q   <= 1'b0;
         count_q <= 12'd0;
         snap_q  <= 16'h0000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         exp_q   <= exp_d;
         timer_q <= timer_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         count_q <= count_d;
         snap_q  <= snap_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         prev_q  <= prev_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign count    = count_q;
   assign overflow = ovf_q;
   assign snapshot = snap_q;

endmodule

// File: tb/tb_iro_meter.sv
// Scoreboard bench for iro_meter: stimulus pushes expected results, a monitor checks each done pulse.
module tb_iro_meter;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] phases;
   logic [3:0]  sel_i;
   logic [3:0]  gate_i;
   logic        start;
   logic        busy;
   logic        done;
   logic [11:0] count;
   logic        overflow;
   logic [15:0] snapshot;

   typedef struct {
      logic [11:0] cnt;
      logic        ovf;
      logic [15:0] snap;
      logic        chk_snap;
      int          exp_cyc;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   per0  = 0;
   int   per5  = 0;
   logic [15:0] fixed_ph = 16'h0000;

`ifdef IRO_METER_SNAPSHOT_EN
   localparam logic [15:0] SNAP_EXP = 16'hA5C3;
`else
   localparam logic [15:0] SNAP_EXP = 16'h0000;
`endif

   iro_meter dut (
      .clk       (clk),
      .rst       (rst),
      .phases    (phases),
      .sel       (sel_i),
      .gate_log2 (gate_i),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .count     (count),
      .overflow  (overflow),
      .snapshot  (snapshot)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Phase generator: taps change on the falling edge
   initial begin
      int t = 0;
      logic [15:0] v;
      phases = 16'h0000;
      forever begin
         @(negedge clk);
         t++;
         v = fixed_ph;
         if (per0 > 0) v[0] = ((t % per0) < (per0 / 2));
         if (per5 > 0) v[5] = ((t % per5) < (per5 / 2));
         phases = v;
      end
   end

   // Monitor: every done pulse is matched against the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("done_cycle", cyc, e.exp_cyc);
            chk("count", {20'd0, count}, {20'd0, e.cnt});
            chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
            if (e.chk_snap) chk("snapshot", {16'd0, snapshot}, {16'd0, e.snap});
         end
      end
   end

   // Issue a start pulse (called just after a falling edge) and log the expected result
   task automatic do_start(input logic [3:0] s, input logic [3:0] g, input logic [11:0] ec,
                           input logic eo, input logic [15:0] es, input logic cs);
      exp_t e;
      int   ge;
      ge = (g > 4'd11) ? 11 : int'(g);
      e.cnt      = ec;
      e.ovf      = eo;
      e.snap     = es;
      e.chk_snap = cs;
      e.exp_cyc  = cyc + 4 + (1 << (ge + 4));
      sb.push_back(e);
      sel_i  = s;
      gate_i = g;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         chk("done_timeout", 32'd1, 32'd0);
         sb.delete();
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int c;
      rst    = 1'b1;
      start  = 1'b0;
      sel_i  = 4'd0;
      gate_i = 4'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_count", {20'd0, count}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_snapshot", {16'd0, snapshot}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Scenario 1: period-4 tap, 16-cycle window
      per0 = 4;
      do_start(4'd0, 4'd0, 12'd4, 1'b0, 16'h0000, 1'b0);
      drain(100);

      // Scenario 2: tap 5 period 8 over 128 cycles, tap 0 toggling as a distractor
      per0 = 2;
      per5 = 8;
      do_start(4'd5, 4'd3, 12'd16, 1'b0, 16'h0000, 1'b0);
      drain(300);

      // Scenario 3: gate clamped to 11, counter saturates
      per5 = 0;
      do_start(4'd0, 4'd15, 12'd4095, 1'b1, 16'h0000, 1'b0);
      drain(33000);

      // Scenario 4: start re-pulsed in ARM, COUNT and DONE; overflow from scenario 3 cleared
      per0 = 4;
      c = cyc;
      do_start(4'd0, 4'd0, 12'd4, 1'b0, 16'h0000, 1'b0);
      for (int k = 1; k <= 25; k++) begin
         if (k > 1) @(negedge clk);
         start = (k == 2 || k == 10 || k == 20) ? 1'b1 : 1'b0;
         chk($sformatf("busy_k%0d", cyc - c), {31'd0, busy},
             {31'd0, ((cyc - c) >= 1 && (cyc - c) <= 19)});
      end
      start = 1'b0;
      drain(50);

      // Scenario 5: reset in the middle of COUNT
      c = cyc;
      sel_i  = 4'd0;
      gate_i = 4'd0;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < c + 10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_count", {20'd0, count}, 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (k == 15) chk("abort_idle_busy", {31'd0, busy}, 32'd0);
      end
      do_start(4'd0, 4'd0, 12'd4, 1'b0, 16'h0000, 1'b0);
      drain(100);

      // Scenario 6: constant taps captured into snapshot
      per0 = 0;
      fixed_ph = 16'hA5C3;
      repeat (5) @(negedge clk);
      do_start(4'd0, 4'd0, 12'd0, 1'b0, SNAP_EXP, 1'b1);
      drain(100);
      chk("snapshot_hold", {16'd0, snapshot}, {16'd0, SNAP_EXP});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
